// File: rtl/servo_seq_ctrl_if.sv
// Host-side bus of servo_seq_ctrl: sequence control, waypoint table writes, PWM/status outputs.
interface servo_seq_ctrl_if;
   logic        start;
   logic        stop;
   logic        loop_en;
   logic [3:0]  num_wp;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [26:0] wr_data;
   logic        pwm1;
   logic [14:0] jiaodu;
   logic        frame_tick;
   logic        busy;
   logic        done;
   logic [2:0]  wp_idx;

   modport master (
      output start, stop, loop_en, num_wp, wr_en, wr_addr, wr_data,
      input  pwm1, jiaodu, frame_tick, busy, done, wp_idx
   );

   modport slave (
      input  start, stop, loop_en, num_wp, wr_en, wr_addr, wr_data,
      output pwm1, jiaodu, frame_tick, busy, done, wp_idx
   );
endinterface

// File: rtl/servo_seq_ctrl.sv
// Waypoint sequencer and PWM generator for one hobby servo channel.
// Optional SERVO_SEQ_SOFTSTOP_EN: stop ramps back to PW_INIT before going idle.
module servo_seq_ctrl #(
   parameter int TICK_DIV = 125,
   parameter int FRAME_US = 20000,
   parameter int DEPTH    = 8,
   parameter int PW_MIN   = 500,
   parameter int PW_MAX   = 2500,
   parameter int PW_INIT  = 1500
) (
   input  logic          clk,
   input  logic          rst,
   servo_seq_ctrl_if.slave bus
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int FW = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_US - 1);
   localparam logic [14:0]   PW_MIN_C   = 15'(PW_MIN);
   localparam logic [14:0]   PW_MAX_C   = 15'(PW_MAX);
   localparam logic [14:0]   PW_INIT_C  = 15'(PW_INIT);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RAMP, S_DWELL} state_t;

   logic [TW-1:0] tick_q, tick_d;
   logic [FW-1:0] fc_q, fc_d;
   logic          frame_tick_q, frame_tick_d;
   logic          pwm1_q, pwm1_d;

   state_t        state_q, state_d;
   logic [14:0]   jiaodu_q, jiaodu_d;
   logic [14:0]   tgt_q, tgt_d;
   logic [3:0]    spd_q, spd_d;
   logic [7:0]    dwl_q, dwl_d;
   logic [7:0]    dcnt_q, dcnt_d;
   logic [2:0]    wp_idx_q, wp_idx_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef SERVO_SEQ_SOFTSTOP_EN
   logic          soft_q, soft_d;
`endif

   logic [26:0]   tbl_q [DEPTH];
   logic [26:0]   wr_entry_d;
   logic [26:0]   rd_entry;
   logic [15:0]   diff;
   logic [15:0]   spd16;
   logic [14:0]   ramp_val;
   logic [3:0]    next_idx;

   function automatic logic [26:0] clamp_entry(input logic [26:0] w);
      logic [14:0] t;
      if (w[14:0] < PW_MIN_C) begin
         t = PW_MIN_C;
      end else if (w[14:0] > PW_MAX_C) begin
         t = PW_MAX_C;
      end else begin
         t = w[14:0];
      end
      return {w[26:15], t};
   endfunction

   // Timebase and PWM compare; frame_tick marks the cycle in which fc has just wrapped to 0.
   always_comb begin
      tick_d       = tick_q;
      fc_d         = fc_q;
      frame_tick_d = 1'b0;
      if (tick_q == TICK_LAST) begin
         tick_d = '0;
         if (fc_q == FRAME_LAST) begin
            fc_d         = '0;
            frame_tick_d = 1'b1;
         end else begin
            fc_d = fc_q + FW'(1);
         end
      end else begin
         tick_d = tick_q + TW'(1);
      end
      pwm1_d = (16'(fc_q) < {1'b0, jiaodu_q});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_q       <= '0;
         fc_q         <= '0;
         frame_tick_q <= 1'b0;
         pwm1_q       <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         fc_q         <= fc_d;
         frame_tick_q <= frame_tick_d;
         pwm1_q       <= pwm1_d;
      end
   end

   always_comb begin
      wr_entry_d = clamp_entry(bus.wr_data);
   end

   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         tbl_q[bus.wr_addr[AW-1:0]] <= wr_entry_d;
      end
   end

   // One ramp step toward tgt; the distance is compared first so the step never overshoots or wraps.
   always_comb begin
      spd16 = {12'd0, spd_q};
      if (jiaodu_q < tgt_q) begin
         diff     = {1'b0, tgt_q} - {1'b0, jiaodu_q};
         ramp_val = (diff > spd16) ? (jiaodu_q + 15'(spd_q)) : tgt_q;
      end else begin
         diff     = {1'b0, jiaodu_q} - {1'b0, tgt_q};
         ramp_val = (diff > spd16) ? (jiaodu_q - 15'(spd_q)) : tgt_q;
      end
   end

   always_comb begin
      state_d  = state_q;
      jiaodu_d = jiaodu_q;
      tgt_d    = tgt_q;
      spd_d    = spd_q;
      dwl_d    = dwl_q;
      dcnt_d   = dcnt_q;
      wp_idx_d = wp_idx_q;
      done_d   = 1'b0;
      rd_entry = tbl_q[wp_idx_q[AW-1:0]];
      next_idx = {1'b0, wp_idx_q} + 4'd1;
`ifdef SERVO_SEQ_SOFTSTOP_EN
      soft_d   = soft_q;
      if (bus.stop) begin
         state_d = S_RAMP;
         tgt_d   = PW_INIT_C;
         dwl_d   = 8'd0;
         soft_d  = 1'b1;
         if (state_q == S_IDLE) begin
            spd_d = 4'd1;
         end else begin
            spd_d = spd_q;
         end
      end else begin
`else
      // In IDLE this also swallows a simultaneous start.
      if (bus.stop) begin
         state_d = S_IDLE;
      end else begin
`endif
         case (state_q)
            S_IDLE: begin
               if (bus.start && (bus.num_wp != 4'd0)) begin
                  state_d  = S_LOAD;
                  wp_idx_d = 3'd0;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_LOAD: begin
               tgt_d   = rd_entry[14:0];
               spd_d   = (rd_entry[18:15] == 4'd0) ? 4'd1 : rd_entry[18:15];
               dwl_d   = rd_entry[26:19];
               state_d = S_RAMP;
            end
            S_RAMP: begin
               if (frame_tick_q) begin
                  jiaodu_d = ramp_val;
               end else begin
                  jiaodu_d = jiaodu_q;
               end
               if (jiaodu_d == tgt_q) begin
`ifdef SERVO_SEQ_SOFTSTOP_EN
                  if (soft_q) begin
                     state_d = S_IDLE;
                     soft_d  = 1'b0;
                  end else begin
                     state_d = S_DWELL;
                     dcnt_d  = dwl_q;
                  end
`else
                  state_d = S_DWELL;
                  dcnt_d  = dwl_q;
`endif
               end else begin
                  state_d = S_RAMP;
               end
            end
            S_DWELL: begin
               if (frame_tick_q) begin
                  if (dcnt_q != 8'd0) begin
                     dcnt_d = dcnt_q - 8'd1;
                  end else if (next_idx < bus.num_wp) begin
                     wp_idx_d = next_idx[2:0];
                     state_d  = S_LOAD;
                  end else if (bus.loop_en) begin
                     wp_idx_d = 3'd0;
                     state_d  = S_LOAD;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  dcnt_d = dcnt_q;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
      busy_d = (state_d != S_IDLE);
   end

   // Sequencer state and its registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         jiaodu_q <= PW_INIT_C;
         tgt_q    <= '0;
         spd_q    <= '0;
         dwl_q    <= '0;
         dcnt_q   <= '0;
         wp_idx_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef SERVO_SEQ_SOFTSTOP_EN
         soft_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         jiaodu_q <= jiaodu_d;
         tgt_q    <= tgt_d;
         spd_q    <= spd_d;
         dwl_q    <= dwl_d;
         dcnt_q   <= dcnt_d;
         wp_idx_q <= wp_idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef SERVO_SEQ_SOFTSTOP_EN
         soft_q   <= soft_d;
`endif
      end
   end

   assign bus.pwm1       = pwm1_q;
   assign bus.jiaodu     = jiaodu_q;
   assign bus.frame_tick = frame_tick_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.wp_idx     = wp_idx_q;
endmodule

// File: tb/tb_servo_seq_ctrl.sv
// Directed bench for servo_seq_ctrl with a shrunk timebase (2 clk/us, 100 us frame).
module tb_servo_seq_ctrl;
   localparam int TICK_DIV  = 2;
   localparam int FRAME_US  = 100;
   localparam int FRAME_CLK = TICK_DIV * FRAME_US;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   servo_seq_ctrl_if bus();

   servo_seq_ctrl #(
      .TICK_DIV(TICK_DIV), .FRAME_US(FRAME_US), .DEPTH(8),
      .PW_MIN(10), .PW_MAX(90), .PW_INIT(50)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Returns at the first negedge after a frame_tick, when jiaodu reflects that frame's update.
   task automatic wait_ft();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 2 * FRAME_CLK && !seen; i++) begin
         @(negedge clk);
         if (bus.frame_tick === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL frame_tick_timeout got none required a pulse within %0d clk", 2 * FRAME_CLK);
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic write_wp(input logic [2:0] a, input logic [7:0] dw,
                           input logic [3:0] sp, input logic [14:0] tg);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = {dw, sp, tg};
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (bus.jiaodu !== 15'd50) begin errors++; $display("FAIL reset_jiaodu got %0d expected 50", bus.jiaodu); end
      checks++; if (bus.pwm1 !== 1'b0) begin errors++; $display("FAIL reset_pwm1 got %b expected 0", bus.pwm1); end
      checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_frame_tick got %b expected 0", bus.frame_tick); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", bus.done); end
      checks++; if (bus.wp_idx !== 3'd0) begin errors++; $display("FAIL reset_wp_idx got %0d expected 0", bus.wp_idx); end
      rst = 1'b0;
   endtask

   task automatic test_pwm_idle();
      int high_cnt;
      int tick_cnt;
      int first_tick;
      high_cnt   = 0;
      tick_cnt   = 0;
      first_tick = -1;
      wait_ft();
      for (int i = 1; i <= 2 * FRAME_CLK; i++) begin
         @(negedge clk);
         if (bus.pwm1 === 1'b1) high_cnt++;
         if (bus.frame_tick === 1'b1) begin
            tick_cnt++;
            if (first_tick < 0) first_tick = i;
         end
      end
      checks++; if (high_cnt != 200) begin errors++; $display("FAIL pwm_high_clk got %0d expected 200", high_cnt); end
      checks++; if (tick_cnt != 2) begin errors++; $display("FAIL frame_tick_count got %0d expected 2", tick_cnt); end
      checks++; if (first_tick != FRAME_CLK - 1) begin errors++; $display("FAIL frame_period got %0d expected %0d", first_tick, FRAME_CLK - 1); end
      checks++; if (bus.jiaodu !== 15'd50) begin errors++; $display("FAIL idle_jiaodu got %0d expected 50", bus.jiaodu); end
   endtask

   task automatic test_ramp_dwell();
      logic [14:0] exp_j [3];
      exp_j = '{15'd54, 15'd58, 15'd62};
      write_wp(3'd0, 8'd2, 4'd4, 15'd62);
      bus.num_wp  = 4'd1;
      bus.loop_en = 1'b0;
      wait_ft();
      pulse_start();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL ramp_busy_start got %b expected 1", bus.busy); end
      for (int k = 0; k < 3; k++) begin
         wait_ft();
         checks++; if (bus.jiaodu !== exp_j[k]) begin errors++; $display("FAIL ramp_step%0d got %0d expected %0d", k, bus.jiaodu, exp_j[k]); end
      end
      for (int k = 0; k < 2; k++) begin
         wait_ft();
         checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.jiaodu !== 15'd62) begin
            errors++; $display("FAIL dwell%0d got busy=%b done=%b jiaodu=%0d expected busy=1 done=0 jiaodu=62", k, bus.busy, bus.done, bus.jiaodu);
         end
      end
      wait_ft();
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL seq_end got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width got %b expected 0", bus.done); end
   endtask

   task automatic test_undershoot();
      do_reset();
      write_wp(3'd0, 8'd0, 4'd5, 15'd47);
      bus.num_wp = 4'd1;
      wait_ft();
      pulse_start();
      wait_ft();
      checks++; if (bus.jiaodu !== 15'd47) begin errors++; $display("FAIL down_step got %0d expected 47", bus.jiaodu); end
      wait_ft();
      checks++; if (bus.done !== 1'b1 || bus.jiaodu !== 15'd47) begin errors++; $display("FAIL down_end got done=%b jiaodu=%0d expected done=1 jiaodu=47", bus.done, bus.jiaodu); end
   endtask

   task automatic test_clamp_speed0();
      logic [14:0] exp_j [6];
      logic [2:0]  exp_i [6];
      exp_j = '{15'd65, 15'd80, 15'd90, 15'd90, 15'd89, 15'd88};
      exp_i = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
      do_reset();
      write_wp(3'd0, 8'd0, 4'd15, 15'd200);
      write_wp(3'd1, 8'd0, 4'd0, 15'd88);
      bus.num_wp  = 4'd2;
      bus.loop_en = 1'b0;
      wait_ft();
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         wait_ft();
         checks++; if (bus.jiaodu !== exp_j[k] || bus.wp_idx !== exp_i[k]) begin
            errors++; $display("FAIL clamp_step%0d got jiaodu=%0d idx=%0d expected jiaodu=%0d idx=%0d", k, bus.jiaodu, bus.wp_idx, exp_j[k], exp_i[k]);
         end
      end
      wait_ft();
      checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL clamp_done got %b expected 1", bus.done); end
   endtask

   task automatic test_loop_stop();
      logic [14:0] exp_j [8];
      logic [2:0]  exp_i [8];
      exp_j = '{15'd60, 15'd60, 15'd55, 15'd50, 15'd50, 15'd60, 15'd60, 15'd55};
      exp_i = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1};
      do_reset();
      write_wp(3'd0, 8'd0, 4'd10, 15'd60);
      write_wp(3'd1, 8'd0, 4'd5, 15'd50);
      bus.num_wp  = 4'd2;
      bus.loop_en = 1'b1;
      wait_ft();
      pulse_start();
      for (int k = 0; k < 8; k++) begin
         wait_ft();
         checks++; if (bus.jiaodu !== exp_j[k] || bus.wp_idx !== exp_i[k]) begin
            errors++; $display("FAIL loop_step%0d got jiaodu=%0d idx=%0d expected jiaodu=%0d idx=%0d", k, bus.jiaodu, bus.wp_idx, exp_j[k], exp_i[k]);
         end
      end
      @(negedge clk);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
`ifdef SERVO_SEQ_SOFTSTOP_EN
      checks++; if (bus.busy !== 1'b1 || bus.jiaodu !== 15'd55) begin errors++; $display("FAIL softstop_enter got busy=%b jiaodu=%0d expected busy=1 jiaodu=55", bus.busy, bus.jiaodu); end
      wait_ft();
      checks++; if (bus.busy !== 1'b0 || bus.jiaodu !== 15'd50 || bus.done !== 1'b0) begin
         errors++; $display("FAIL softstop_end got busy=%b jiaodu=%0d done=%b expected busy=0 jiaodu=50 done=0", bus.busy, bus.jiaodu, bus.done);
      end
`else
      checks++; if (bus.busy !== 1'b0 || bus.jiaodu !== 15'd55) begin errors++; $display("FAIL stop_idle got busy=%b jiaodu=%0d expected busy=0 jiaodu=55", bus.busy, bus.jiaodu); end
      wait_ft();
      checks++; if (bus.busy !== 1'b0 || bus.jiaodu !== 15'd55 || bus.done !== 1'b0) begin
         errors++; $display("FAIL stop_hold got busy=%b jiaodu=%0d done=%b expected busy=0 jiaodu=55 done=0", bus.busy, bus.jiaodu, bus.done);
      end
`endif
      bus.loop_en = 1'b0;
   endtask

   task automatic test_start_stop_same();
      bus.num_wp = 4'd2;
      @(negedge clk);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_stop_same got busy=%b expected 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      write_wp(3'd0, 8'd0, 4'd10, 15'd60);
      bus.num_wp = 4'd1;
      wait_ft();
      pulse_start();
      wait_ft();
      repeat (10) @(negedge clk);
      checks++; if (bus.pwm1 !== 1'b1 || bus.jiaodu !== 15'd60) begin errors++; $display("FAIL pre_reset got pwm1=%b jiaodu=%0d expected pwm1=1 jiaodu=60", bus.pwm1, bus.jiaodu); end
      rst = 1'b1;
      #1;
      checks++; if (bus.pwm1 !== 1'b0 || bus.jiaodu !== 15'd50 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL async_reset got pwm1=%b jiaodu=%0d busy=%b expected pwm1=0 jiaodu=50 busy=0", bus.pwm1, bus.jiaodu, bus.busy);
      end
      @(negedge clk);
      rst = 1'b0;
      bus.num_wp = 4'd0;
      pulse_start();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL numwp0_start got busy=%b expected 0", bus.busy); end
      repeat (5) @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.wp_idx !== 3'd0) begin errors++; $display("FAIL numwp0_hold got busy=%b idx=%0d expected busy=0 idx=0", bus.busy, bus.wp_idx); end
   endtask

   initial begin
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.loop_en = 1'b0;
      bus.num_wp  = 4'd0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = 3'd0;
      bus.wr_data = 27'd0;
      test_reset();
      test_pwm_idle();
      test_ramp_dwell();
      test_undershoot();
      test_clamp_speed0();
      test_loop_stop();
`ifndef SERVO_SEQ_SOFTSTOP_EN
      test_start_stop_same();
`endif
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
